// File: rtl/bsg_chip_link_out_arbiter_pkg.sv
// Shared types and constants for the chip comm-link output arbiter.
package bsg_chip_link_pkg;

   localparam int unsigned link_width_gp         = 9;
   localparam int unsigned link_payload_width_gp = 8;
   localparam int unsigned link_num_req_gp       = 2;

   typedef struct packed {
      logic                             id;
      logic [link_payload_width_gp-1:0] payload;
   } link_word_s;

   function automatic link_word_s make_link_word(input logic                             id,
                                                 input logic [link_payload_width_gp-1:0] payload);
      link_word_s w;
      w.id      = id;
      w.payload = payload;
      return w;
   endfunction

endpackage

// File: rtl/bsg_chip_link_out_arbiter_if.sv
// Requester/link-side bundle of the comm-link output arbiter; slave = arbiter side.
interface bsg_chip_link_out_if #(
   parameter int unsigned max_credits_p = 16
);
   import bsg_chip_link_pkg::*;

   localparam int unsigned lg_credits_lp = $clog2(max_credits_p + 1);

   logic [link_num_req_gp-1:0]                            req_v_i;
   logic [link_num_req_gp-1:0][link_payload_width_gp-1:0] req_data_i;
   logic [link_num_req_gp-1:0]                            req_yumi_o;
   logic                                                  link_v_o;
   logic [link_width_gp-1:0]                              link_data_o;
   logic                                                  link_tkn_i;
   logic [lg_credits_lp-1:0]                              credits_o;
   logic                                                  credit_overflow_o;

   modport slave (
      input  req_v_i, req_data_i, link_tkn_i,
      output req_yumi_o, link_v_o, link_data_o, credits_o, credit_overflow_o
   );

   modport master (
      output req_v_i, req_data_i, link_tkn_i,
      input  req_yumi_o, link_v_o, link_data_o, credits_o, credit_overflow_o
   );

endinterface

// File: rtl/bsg_chip_link_out_arbiter_rr.sv
// Two-input round-robin arbiter (hold_on_valid=0); pointer moves only on an accepted grant.
module bsg_round_robin_arb (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] reqs_i,
   input  logic       yumi_i,
   output logic [1:0] grants_o
);

   logic       r_last;
   logic       w_last_n;
   logic [1:0] w_grant;

   always_comb begin
      w_grant = 2'b00;
      unique case (reqs_i)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
         default: w_grant = 2'b00;
      endcase
   end

   always_comb begin
      w_last_n = r_last;
      if (yumi_i && (w_grant != 2'b00)) begin
         w_last_n = w_grant[1];
      end
   end

   // Reset to 1 so requester 0 wins the first contended grant.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_last <= 1'b1;
      end else begin
         r_last <= w_last_n;
      end
   end

   assign grants_o = w_grant;

endmodule

// File: rtl/bsg_chip_link_out_arbiter.sv
// Credit-metered, round-robin scheduler of two requesters onto one 9-bit comm-link channel.
// Optional stall counter port enabled by BSG_CHIP_LINK_ARB_STALL_CNT_EN.
module bsg_chip_link_out_arbiter
   import bsg_chip_link_pkg::*;
#(
   parameter int unsigned max_credits_p = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   bsg_chip_link_out_if.slave      link_if
`ifdef BSG_CHIP_LINK_ARB_STALL_CNT_EN
   ,
   output logic [31:0]             stall_cnt_o
`endif
);

   localparam int unsigned lg_credits_lp = $clog2(max_credits_p + 1);
   localparam logic [lg_credits_lp-1:0] MaxCredits = lg_credits_lp'(max_credits_p);
   localparam logic [lg_credits_lp-1:0] OneCredit  = lg_credits_lp'(1);

   logic [lg_credits_lp-1:0] r_credits;
   logic [lg_credits_lp-1:0] w_credits_n;
   logic                     r_overflow;
   logic                     w_overflow_n;
   logic                     r_link_v;
   link_word_s               r_link_data;
   link_word_s               w_word;
   logic                     w_eligible;
   logic                     w_send;
   logic [1:0]               w_grant;
   logic [1:0]               w_yumi;

   // Only the registered count qualifies a send; a same-cycle token cannot help.
   assign w_eligible = (r_credits != '0) && !reset_i;

   bsg_round_robin_arb u_rr (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .reqs_i   (link_if.req_v_i),
      .yumi_i   (w_eligible),
      .grants_o (w_grant)
   );

   assign w_yumi = w_grant & {2{w_eligible}};
   assign w_send = |w_yumi;

   always_comb begin
      w_word = make_link_word(w_yumi[1], link_if.req_data_i[w_yumi[1]]);
   end

   always_comb begin
      w_credits_n  = r_credits;
      w_overflow_n = r_overflow;
      unique case ({w_send, link_if.link_tkn_i})
         2'b10: w_credits_n = r_credits - OneCredit;
         2'b01: begin
            if (r_credits == MaxCredits) begin
               w_overflow_n = 1'b1;
            end else begin
               w_credits_n = r_credits + OneCredit;
            end
         end
         default: w_credits_n = r_credits;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_credits   <= MaxCredits;
         r_overflow  <= 1'b0;
         r_link_v    <= 1'b0;
         r_link_data <= '0;
      end else begin
         r_credits  <= w_credits_n;
         r_overflow <= w_overflow_n;
         r_link_v   <= w_send;
         if (w_send) begin
            r_link_data <= w_word;
         end
      end
   end

`ifdef BSG_CHIP_LINK_ARB_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_stall_cnt <= '0;
      end else if ((|link_if.req_v_i) && (r_credits == '0)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

   assign link_if.req_yumi_o        = w_yumi;
   assign link_if.link_v_o          = r_link_v;
   assign link_if.link_data_o       = r_link_data;
   assign link_if.credits_o         = r_credits;
   assign link_if.credit_overflow_o = r_overflow;

endmodule
